mc_controller: RTL and testbench

Control unit for the multicycle ARM datapath, the successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, one datapath step per clock. It generates all datapath mux selects and write enables, the 2-bit ALU operation, and the gated PC, register and memory writes. It owns the architectural NZCV flag register and evaluates the ARM condition field.

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_controller_cond.sv | 40 ++++
 rtl/mc_controller.sv | 111 +++++++++++
 tb/tb_mc_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, ALU commands, condition codes and the per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic [1:0] IMM_8 = 2'b00, IMM_12 = 2'b01, IMM_24 = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.ir_write = 1'b1; c.next_pc = 1'b1; c.alu_src_a = 1'b1;
                      c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
      S_DECODE: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB:  begin c.result_src = RES_DATA; c.reg_w = 1'b1; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_EXECR:  begin c.alu_src_b = SRCB_REG; c.alu_op = 1'b1; end
      S_EXECI:  begin c.alu_src_b = SRCB_IMM; c.alu_op = 1'b1; end
      S_ALUWB:  begin c.result_src = RES_ALUOUT; c.reg_w = 1'b1; end
      S_BRANCH: begin c.alu_src_b = SRCB_IMM; c.result_src = RES_ALURES; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // nzcv = {N,Z,C,V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c & !z;
      COND_LS: cond_holds = !c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_cond.sv
// Architectural NZCV register plus the condition-pass flop that gates every
// write of the instruction in flight.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic       flag_upd,
  input  logic       cv_upd,
  output logic       cond_ex_q
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_d;

  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (cond_latch) cond_ex_d = cond_holds(cond, flags_q);
    // Logic ops leave C/V untouched; only add/sub-class commands own them.
    if (flag_upd && cond_ex_q) begin
      flags_d[3:2] = alu_flags[3:2];
      if (cv_upd) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction FSM with a registered per-state
// control word, ALU/immediate decoders and condition-gated write enables.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] cmd;
  logic [1:0] alu_ctl;
  logic       dp_nowrite, cv_upd, no_write, pcs, cond_ex;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: case (Op)
                  2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                  2'b01:   state_d = S_MEMADR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
                endcase
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Write suppression follows the command for the whole data-processing
  // instruction, so CMP stays silent in ALUWB where ALUOp is already low.
  always_comb begin
    cmd        = Funct[4:1];
    alu_ctl    = ALU_ADD;
    dp_nowrite = 1'b0;
    cv_upd     = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_ctl = ALU_ADD; cv_upd = 1'b1; end
      CMD_SUB: begin alu_ctl = ALU_SUB; cv_upd = 1'b1; end
      CMD_AND: alu_ctl = ALU_AND;
      CMD_ORR: alu_ctl = ALU_ORR;
      CMD_CMP: begin alu_ctl = ALU_SUB; cv_upd = 1'b1; dp_nowrite = 1'b1; end
      default: dp_nowrite = 1'b1;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_8;
    RegSrc = 2'b00;
    case (Op)
      2'b01:   begin ImmSrc = IMM_12; RegSrc = 2'b10; end
      2'b10:   begin ImmSrc = IMM_24; RegSrc = 2'b01; end
      default: begin ImmSrc = IMM_8;  RegSrc = 2'b00; end
    endcase
  end

  cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (Cond),
    .alu_flags  (ALUFlags),
    .cond_latch (state_q == S_DECODE),
    .flag_upd   ((state_q == S_EXECR || state_q == S_EXECI) && Funct[0]),
    .cv_upd     (cv_upd),
    .cond_ex_q  (cond_ex)
  );

  assign no_write   = (Op == 2'b00) && dp_nowrite;
  assign pcs        = ((Rd == 4'hF) && ctrl_q.reg_w) || ctrl_q.branch;
  assign PCWrite    = !reset && (ctrl_q.next_pc || (pcs && cond_ex));
  assign RegWrite   = !reset && ctrl_q.reg_w && cond_ex && !no_write;
  assign MemWrite   = !reset && ctrl_q.mem_w && cond_ex;
  assign IRWrite    = !reset && ctrl_q.ir_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUControl = ctrl_q.alu_op ? alu_ctl : ALU_ADD;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: instructions are expanded into their
// phase lists and each cycle's controls are predicted from the state table.
`timescale 1ns/1ps
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_B} ph_e;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] flags_m;
  logic       condex_m;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] obs_wr();
    return {PCWrite, MemWrite, RegWrite, IRWrite};
  endfunction

  function automatic logic [11:0] obs_sel();
    logic [1:0] rs;
    rs = (Op == 2'b10) ? {1'b0, RegSrc[0]} : RegSrc;
    return {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, rs, ALUControl};
  endfunction

  task automatic expect_out(input ph_e p, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, output logic [3:0] wr, output logic [11:0] sel);
    logic irw, npc, adr, sa, regw, memw, br, aluop, nw;
    logic [1:0] sb, rs, alu, imm, rsrc;
    logic [3:0] cmd;
    irw = 0; npc = 0; adr = 0; sa = 0; regw = 0; memw = 0; br = 0; aluop = 0;
    sb = 2'b00; rs = 2'b00; cmd = fn[4:1];
    case (p)
      P_F:   begin irw = 1; npc = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      P_D:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      P_MA:  sb = 2'b01;
      P_MR:  adr = 1;
      P_MWB: begin rs = 2'b01; regw = 1; end
      P_MW:  begin adr = 1; memw = 1; end
      P_ER:  begin sb = 2'b00; aluop = 1; end
      P_EI:  begin sb = 2'b01; aluop = 1; end
      P_AWB: begin rs = 2'b00; regw = 1; end
      default: begin sb = 2'b01; rs = 2'b10; br = 1; end
    endcase
    alu = 2'b00;
    if (aluop)
      case (cmd)
        4'b0010, 4'b1010: alu = 2'b01;
        4'b0000:          alu = 2'b10;
        4'b1100:          alu = 2'b11;
        default:          alu = 2'b00;
      endcase
    nw   = (op == 2'b00) && !(cmd inside {4'b0000, 4'b0010, 4'b0100, 4'b1100});
    imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    rsrc = (op == 2'b01) ? 2'b10 : (op == 2'b10) ? 2'b01 : 2'b00;
    wr   = {npc || ((((rd == 4'hF) && regw) || br) && condex_m),
            memw && condex_m, regw && condex_m && !nw, irw};
    sel  = {adr, sa, sb, rs, imm, rsrc, alu};
  endtask

  // Entered at a falling edge with the DUT in FETCH; returns likewise.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input int eflags, input int abort_at);
    ph_e ph[$];
    logic [3:0] wr;
    logic [11:0] sel;
    bit is_exec;
    ph.push_back(P_F);
    ph.push_back(P_D);
    case (op)
      2'b00: begin ph.push_back(fn[5] ? P_EI : P_ER); ph.push_back(P_AWB); end
      2'b01: begin
        ph.push_back(P_MA);
        if (fn[0]) begin ph.push_back(P_MR); ph.push_back(P_MWB); end
        else ph.push_back(P_MW);
      end
      2'b10: ph.push_back(P_B);
      default: ;
    endcase
    Cond = c; Op = op; Funct = fn; Rd = rd;
    foreach (ph[k]) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_wr", 12'(obs_wr()), 12'h0);
        flags_m = 4'b0000; condex_m = 1'b0;
        @(negedge clk);
        chk("abort_hold_wr", 12'(obs_wr()), 12'h0);
        chk("abort_nzcv", 12'(dut.u_cond.flags_q), 12'(flags_m));
        reset = 1'b0;
        return;
      end
      is_exec  = (ph[k] == P_ER) || (ph[k] == P_EI);
      ALUFlags = (is_exec && eflags >= 0) ? eflags[3:0] : 4'($urandom);
      #1;
      expect_out(ph[k], op, fn, rd, wr, sel);
      chk("wr", 12'(obs_wr()), 12'(wr));
      chk("sel", obs_sel(), sel);
      if (ph[k] == P_D) condex_m = cond_ok(c, flags_m);
      if (is_exec && fn[0] && condex_m) begin
        flags_m[3:2] = ALUFlags[3:2];
        if (fn[4:1] inside {4'b0100, 4'b0010, 4'b1010}) flags_m[1:0] = ALUFlags[1:0];
      end
      @(negedge clk);
    end
    chk("nzcv", 12'(dut.u_cond.flags_q), 12'(flags_m));
  endtask

  initial begin
    reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
    flags_m = 4'b0000; condex_m = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_wr", 12'(obs_wr()), 12'h0);
    end
    reset = 1'b0;
    run_instr(4'hE, 2'b00, 6'b001000, 4'd1,  -1, -1);      // ADD R1, imm
    run_instr(4'hE, 2'b00, 6'b000101, 4'd2,   4, -1);      // SUBS, Z result
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0,  -1, -1);      // BEQ taken
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0,  -1, -1);      // BNE not taken
    run_instr(4'hE, 2'b01, 6'b011001, 4'd15, -1, -1);      // LDR PC
    run_instr(4'hE, 2'b00, 6'b010101, 4'd3,   9, -1);      // CMP
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4,  -1,  2);      // STR reset at MEMADR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4,  -1, -1);      // STR
    run_instr(4'hF, 2'b00, 6'b001001, 4'd15, -1, -1);      // never-condition
    run_instr(4'hE, 2'b11, 6'b111111, 4'd15, -1, -1);      // unsupported op
    repeat (120) begin
      run_instr(($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom), 2'($urandom),
                6'($urandom), 4'($urandom), -1,
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
